// File: rtl/pool_pkg.sv
// Shared constants and FSM state type for the average-pool scheduler.
package pool_pkg;

   localparam int unsigned POOL_WIN     = 64;
   localparam int unsigned POOL_SHIFT   = 6;
   localparam int unsigned PIPE_LAT_DEF = 6;
   localparam int unsigned RD_LAT_DEF   = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/avg_pool_sched_if.sv
// Control, feature-buffer read and result stream signals of the average-pool scheduler.
interface avg_pool_sched_if #(
   parameter int unsigned CH_W   = 10,
   parameter int unsigned DATA_W = 16
);
   logic              start;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [CH_W-1:0]   rd_ch;
   logic [DATA_W-1:0] pool_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CH_W-1:0]   out_ch;

   modport master (
      input  start, pool_in, out_ready,
      output busy, done, rd_en, rd_ch, out_valid, out_data, out_ch
   );

   modport slave (
      output start, pool_in, out_ready,
      input  busy, done, rd_en, rd_ch, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/pool_out_fifo.sv
// Synchronous first-word-fall-through FIFO holding {channel, scaled result} entries.
module pool_out_fifo #(
   parameter int unsigned W     = 26,
   parameter int unsigned DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [W-1:0]                 push_data,
   input  logic                         pop,
   output logic [W-1:0]                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         valid
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
   endfunction

   assign valid  = (count != '0);
   assign do_pop = pop && valid;
   // Head reads as zero when empty so out_data/out_ch follow reset values.
   assign head   = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= bump(wr_ptr);
         end
         if (do_pop) rd_ptr <= bump(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

   // The issue credit guarantees space for every result already in flight.
   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && !do_pop && 32'(count) == DEPTH));
   end
endmodule

// File: rtl/avg_pool_sched.sv
// Issues one window read per channel, tracks it through the fixed-latency adder tree,
// scales the sum by 1/64 and returns results in channel order.
module avg_pool_sched
   import pool_pkg::*;
#(
   parameter int unsigned NUM_CH     = 1000,
   parameter int unsigned CH_W       = 10,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned RD_LAT     = RD_LAT_DEF,
   parameter int unsigned PIPE_LAT   = PIPE_LAT_DEF,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   avg_pool_sched_if.master bus
);
   localparam int unsigned TRK_LEN = RD_LAT + PIPE_LAT;
   localparam int unsigned FIFO_W  = CH_W + DATA_W;
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned INF_W   = $clog2(TRK_LEN + 1);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   sched_state_t      state_q, state_d;
   logic [CH_W-1:0]   ch_q;
   logic [TRK_LEN-1:0] trk_vld_q;
   logic [CH_W-1:0]   trk_ch_q [TRK_LEN];
   logic [INF_W-1:0]  inflight;
   logic [CNT_W-1:0]  fifo_count;
   logic              credit_ok;
   logic              issue;
   logic              push;
   logic              pop;
   logic              head_valid;
   logic [DATA_W-1:0] scaled;
   logic [FIFO_W-1:0] head;

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < TRK_LEN; i++) inflight = inflight + INF_W'(trk_vld_q[i]);
   end

   // Credit uses the registered FIFO count; a same-cycle pop is not counted.
   assign credit_ok = (32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      unique case (state_q)
         IDLE:  if (bus.start) state_d = ISSUE;
         ISSUE: begin
            issue = credit_ok;
            if (credit_ok && ch_q == LAST_CH) state_d = DRAIN;
         end
         DRAIN: if (inflight == '0 && fifo_count == CNT_W'(1) && pop) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || state_q == IDLE) ch_q <= '0;
      else if (issue)             ch_q <= (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
   end

   // Valid/channel shadow of the read and adder-tree latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         trk_vld_q <= '0;
         for (int unsigned i = 0; i < TRK_LEN; i++) trk_ch_q[i] <= '0;
      end else begin
         trk_vld_q   <= {trk_vld_q[TRK_LEN-2:0], issue};
         trk_ch_q[0] <= ch_q;
         for (int unsigned i = 1; i < TRK_LEN; i++) trk_ch_q[i] <= trk_ch_q[i-1];
      end
   end

   assign scaled = DATA_W'($signed(bus.pool_in) >>> POOL_SHIFT);
   assign push   = trk_vld_q[TRK_LEN-1];
   assign pop    = head_valid && bus.out_ready;

   pool_out_fifo #(
      .W     (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({trk_ch_q[TRK_LEN-1], scaled}),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .valid     (head_valid)
   );

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.rd_en     = issue;
   assign bus.rd_ch     = ch_q;
   assign bus.out_valid = head_valid;
   assign {bus.out_ch, bus.out_data} = head;
endmodule

// File: tb/tb_avg_pool_sched.sv
// Scoreboard bench: three scheduler instances (1, 4 and 20 channels) with a modelled adder tree.
module tb_avg_pool_sched;
   localparam int TREE = 7;
   localparam int LAT  = TREE + 1;
   localparam int NI   = 3;

   logic clk;
   logic rst;

   logic        start_v     [NI];
   logic        ready_v     [NI];
   logic [15:0] pool_v      [NI];
   logic        busy_v      [NI];
   logic        done_v      [NI];
   logic        rd_en_v     [NI];
   logic [9:0]  rd_ch_v     [NI];
   logic        out_valid_v [NI];
   logic [15:0] out_data_v  [NI];
   logic [9:0]  out_ch_v    [NI];

   logic [15:0] val_tab [8] = '{16'h0640, 16'hFFC0, 16'h8000, 16'h003F,
                                16'hFFFF, 16'h7FFF, 16'h0040, 16'hFFBF};
   logic [15:0] exp_tab [8] = '{16'h0019, 16'hFFFF, 16'hFE00, 16'h0000,
                                16'hFFFF, 16'h01FF, 16'h0001, 16'hFFFE};

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_rd[NI], n_out[NI], n_done[NI], exp_rd[NI];
   int first_rd[NI], last_rd[NI], first_out[NI], last_out[NI], last_hs[NI];
   logic [25:0] sb [NI][$];
   logic [9:0]  tree_ch [NI][TREE];

   for (genvar g = 0; g < NI; g++) begin : inst
      localparam int unsigned N = (g == 0) ? 1 : (g == 1) ? 4 : 20;
      avg_pool_sched_if #(.CH_W(10), .DATA_W(16)) bus ();
      assign bus.start      = start_v[g];
      assign bus.out_ready  = ready_v[g];
      assign bus.pool_in    = pool_v[g];
      assign busy_v[g]      = bus.busy;
      assign done_v[g]      = bus.done;
      assign rd_en_v[g]     = bus.rd_en;
      assign rd_ch_v[g]     = bus.rd_ch;
      assign out_valid_v[g] = bus.out_valid;
      assign out_data_v[g]  = bus.out_data;
      assign out_ch_v[g]    = bus.out_ch;
      avg_pool_sched #(.NUM_CH(N)) dut (.clk(clk), .rst(rst), .bus(bus.master));
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Adder-tree model: the sum for a channel reaches pool_in TREE cycles after its read.
   always @(posedge clk) begin
      for (int g = 0; g < NI; g++) begin
         tree_ch[g][0] <= rd_ch_v[g];
         for (int k = 1; k < TREE; k++) tree_ch[g][k] <= tree_ch[g][k-1];
      end
   end
   always_comb begin
      for (int g = 0; g < NI; g++) pool_v[g] = val_tab[tree_ch[g][TREE-1][2:0]];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int g = 0; g < NI; g++) begin
            if (rd_en_v[g]) begin
               check($sformatf("rd_ch[%0d]", g), 64'(rd_ch_v[g]), 64'(exp_rd[g]));
               if (n_rd[g] == 0) first_rd[g] = cyc;
               last_rd[g] = cyc;
               n_rd[g]++;
               sb[g].push_back({10'(exp_rd[g]), exp_tab[exp_rd[g] % 8]});
               exp_rd[g]++;
            end
            if (out_valid_v[g] && ready_v[g]) begin
               if (n_out[g] == 0) first_out[g] = cyc;
               last_out[g] = cyc;
               last_hs[g]  = cyc;
               n_out[g]++;
               n_tests++;
               if (sb[g].size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_out[%0d]: got ch %0d with no result pending", g, out_ch_v[g]);
               end else begin
                  logic [25:0] e;
                  e = sb[g].pop_front();
                  check($sformatf("out_ch[%0d]", g), 64'(out_ch_v[g]), 64'(e[25:16]));
                  check($sformatf("out_data[%0d]", g), 64'(out_data_v[g]), 64'(e[15:0]));
               end
            end
            if (done_v[g]) begin
               n_done[g]++;
               check($sformatf("done_after_hs[%0d]", g), 64'(cyc - last_hs[g]), 64'd1);
               check($sformatf("sb_empty_at_done[%0d]", g), 64'(sb[g].size()), 64'd0);
            end
         end
      end
   end

   task automatic clear_stats(input int g);
      n_rd[g] = 0; n_out[g] = 0; n_done[g] = 0; exp_rd[g] = 0;
      first_rd[g] = 0; last_rd[g] = 0; first_out[g] = 0; last_out[g] = 0; last_hs[g] = 0;
      sb[g].delete();
   endtask

   task automatic pulse(input int g);
      @(posedge clk); #1 start_v[g] = 1'b1;
      @(posedge clk); #1 start_v[g] = 1'b0;
   endtask

   task automatic wait_done(input int g, input int budget);
      int k;
      k = 0;
      while (n_done[g] == 0 && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      if (n_done[g] == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout_done[%0d]: no done within %0d cycles", g, budget);
      end
   endtask

   task automatic check_reset(input int g);
      check($sformatf("rst_busy[%0d]", g),      64'(busy_v[g]),      64'd0);
      check($sformatf("rst_done[%0d]", g),      64'(done_v[g]),      64'd0);
      check($sformatf("rst_rd_en[%0d]", g),     64'(rd_en_v[g]),     64'd0);
      check($sformatf("rst_rd_ch[%0d]", g),     64'(rd_ch_v[g]),     64'd0);
      check($sformatf("rst_out_valid[%0d]", g), 64'(out_valid_v[g]), 64'd0);
      check($sformatf("rst_out_data[%0d]", g),  64'(out_data_v[g]),  64'd0);
      check($sformatf("rst_out_ch[%0d]", g),    64'(out_ch_v[g]),    64'd0);
   endtask

   initial begin
      rst = 1'b1;
      for (int g = 0; g < NI; g++) begin
         start_v[g] = 1'b0;
         ready_v[g] = 1'b1;
         clear_stats(g);
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      for (int g = 0; g < NI; g++) check_reset(g);

      // Single channel: 0x0640 -> 0x0019, latency and done timing.
      clear_stats(0);
      pulse(0);
      wait_done(0, 100);
      check("t1_n_out", 64'(n_out[0]), 64'd1);
      check("t1_latency", 64'(first_out[0] - first_rd[0]), 64'(LAT));
      @(negedge clk); #1;
      check("t1_busy_after", 64'(busy_v[0]), 64'd0);
      check("t1_n_done", 64'(n_done[0]), 64'd1);

      // Four channels back to back, including negative sums.
      clear_stats(1);
      pulse(1);
      wait_done(1, 100);
      check("t3_n_rd", 64'(n_rd[1]), 64'd4);
      check("t3_rd_span", 64'(last_rd[1] - first_rd[1]), 64'd3);
      check("t3_latency", 64'(first_out[1] - first_rd[1]), 64'(LAT));
      check("t3_out_span", 64'(last_out[1] - first_out[1]), 64'd3);
      repeat (5) @(negedge clk);
      #1;
      check("t3_n_out", 64'(n_out[1]), 64'd4);
      check("t3_n_done", 64'(n_done[1]), 64'd1);

      // Second start inside a running layer is dropped.
      clear_stats(1);
      pulse(1);
      repeat (2) @(posedge clk);
      #1 start_v[1] = 1'b1;
      @(posedge clk); #1 start_v[1] = 1'b0;
      wait_done(1, 100);
      repeat (20) @(negedge clk);
      #1;
      check("t6_n_out", 64'(n_out[1]), 64'd4);
      check("t6_n_rd", 64'(n_rd[1]), 64'd4);
      check("t6_n_done", 64'(n_done[1]), 64'd1);
      check("t6_busy", 64'(busy_v[1]), 64'd0);

      // Backpressure: credit stops issue at FIFO_DEPTH outstanding.
      clear_stats(2);
      ready_v[2] = 1'b0;
      pulse(2);
      repeat (30) @(posedge clk);
      @(negedge clk); #1;
      check("t4_n_rd_stalled", 64'(n_rd[2]), 64'd8);
      check("t4_rd_en_stalled", 64'(rd_en_v[2]), 64'd0);
      check("t4_out_valid_stalled", 64'(out_valid_v[2]), 64'd1);
      check("t4_no_done_stalled", 64'(n_done[2]), 64'd0);
      @(posedge clk); #1 ready_v[2] = 1'b1;
      wait_done(2, 300);
      check("t4_n_out", 64'(n_out[2]), 64'd20);
      check("t4_n_rd", 64'(n_rd[2]), 64'd20);
      check("t4_n_done", 64'(n_done[2]), 64'd1);

      // Reset with five reads in flight.
      clear_stats(2);
      pulse(2);
      for (int k = 0; k < 50 && n_rd[2] < 5; k++) begin
         @(negedge clk); #1;
      end
      check("t5_inflight_setup", 64'(n_rd[2]), 64'd5);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      clear_stats(2);
      @(negedge clk); #1;
      check_reset(2);
      repeat (15) @(negedge clk);
      #1;
      check("t5_no_done", 64'(n_done[2]), 64'd0);
      check("t5_no_out", 64'(n_out[2]), 64'd0);
      pulse(2);
      wait_done(2, 300);
      check("t5_rerun_n_out", 64'(n_out[2]), 64'd20);
      check("t5_rerun_n_done", 64'(n_done[2]), 64'd1);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
